// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch-PC sequencing logic.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int STAT_W = 16;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_TGT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/branch_stats_cnt.sv
// Saturating taken / not-taken branch counters, used only when BRANCH_STATS_EN is defined.
module branch_stats_cnt
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_taken_i,
  input  logic              inc_nottaken_i,
  output logic [STAT_W-1:0] taken_cnt_o,
  output logic [STAT_W-1:0] nottaken_cnt_o
);

  logic [STAT_W-1:0] taken_q, taken_d;
  logic [STAT_W-1:0] nottaken_q, nottaken_d;

  always_comb begin
    taken_d    = inc_taken_i    ? sat_inc(taken_q)    : taken_q;
    nottaken_d = inc_nottaken_i ? sat_inc(nottaken_q) : nottaken_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q    <= '0;
      nottaken_q <= '0;
    end else begin
      taken_q    <= taken_d;
      nottaken_q <= nottaken_d;
    end
  end

  assign taken_cnt_o    = taken_q;
  assign nottaken_cnt_o = nottaken_q;

endmodule

// File: rtl/branch_seq_ctrl.sv
// Fetch PC sequencer with taken-branch redirect and timed pipeline flush.
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_seq_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_zero,
  input  logic [31:0] tgt_in,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] nottaken_cnt
`endif
);

  // WAIT_TGT supplies the first flush cycle, so the counter covers the rest.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            taken;
  logic            in_run;

  assign taken    = br_valid & br_zero;
  assign in_run   = (state_q == RUN);
  assign pc_plus4 = pc_q + PC_STEP;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (taken) begin
          state_d = WAIT_TGT;
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
      end
      WAIT_TGT: begin
        pc_d    = tgt_in;
        cnt_d   = CNT_INIT;
        state_d = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
      end
      FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc    = pc_q;
  assign flush = !in_run;
  assign busy  = !in_run;

`ifdef BRANCH_STATS_EN
  // Branches seen outside RUN are on the wrong path and are not counted.
  branch_stats_cnt u_stats (
    .clk            (clk),
    .rst            (rst),
    .inc_taken_i    (in_run & taken),
    .inc_nottaken_i (in_run & br_valid & !br_zero),
    .taken_cnt_o    (taken_cnt),
    .nottaken_cnt_o (nottaken_cnt)
  );
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Scoreboard bench for branch_seq_ctrl: a cycle model pushes expected outputs, compared after each edge.
module tb_branch_seq_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FC       = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_zero = 1'b0;
  logic [31:0] tgt_in = '0;
  logic [31:0] pc, pc_plus4;
  logic        flush, busy;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt, nottaken_cnt;
`endif

  always #5 clk = ~clk;

  branch_seq_ctrl #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FC)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .br_valid (br_valid),
    .br_zero  (br_zero),
    .tgt_in   (tgt_in),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .flush    (flush),
    .busy     (busy)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic [15:0] tk;
    logic [15:0] nt;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 = running, 1 = waiting for target, 2 = flushing.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_pc    = RESET_PC;
  logic [15:0] m_tk    = '0;
  logic [15:0] m_nt    = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic step(input logic r, input logic s, input logic bv, input logic bz,
                      input logic [31:0] tgt);
    exp_t e;
    rst = r; stall = s; br_valid = bv; br_zero = bz; tgt_in = tgt;
    if (r) begin
      m_phase = 0; m_pc = RESET_PC; m_left = 0; m_tk = '0; m_nt = '0;
    end else begin
      case (m_phase)
        0: begin
          if (bv && bz) begin
            m_phase = 1;
            m_tk = sat16(m_tk);
          end else begin
            if (bv) m_nt = sat16(m_nt);
            if (!s) m_pc = m_pc + 32'd4;
          end
        end
        1: begin
          m_pc = tgt;
          m_left = FC - 1;
          m_phase = (m_left == 0) ? 0 : 2;
        end
        default: begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 0;
        end
      endcase
    end
    e.pc = m_pc; e.flush = (m_phase != 0); e.tk = m_tk; e.nt = m_nt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      chk("flush", {31'd0, flush}, {31'd0, e.flush});
      chk("busy", {31'd0, busy}, {31'd0, e.flush});
`ifdef BRANCH_STATS_EN
      chk("taken_cnt", {16'd0, taken_cnt}, {16'd0, e.tk});
      chk("nottaken_cnt", {16'd0, nottaken_cnt}, {16'd0, e.nt});
`endif
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset and straight-line fetch.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    run(3);
    chk("seq_pc_c", pc, 32'hC);
    run(1);
    chk("pc_10", pc, 32'h10);

    // Stall holds the PC.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_hold", pc, 32'h10);
    run(1);
    chk("stall_resume", pc, 32'h14);
    run(3);
    chk("pc_20", pc, 32'h20);

    // Taken branch at 0x20 to 0x100, with a branch arriving during FLUSH.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    chk("wait_pc_hold", pc, 32'h20);
    chk("wait_flush", {31'd0, flush}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    chk("redir_pc", pc, 32'h100);
    chk("flush2", {31'd0, flush}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h300);
    chk("flush_end", {31'd0, flush}, 32'd0);
    chk("ignored_br_pc", pc, 32'h100);
`ifdef BRANCH_STATS_EN
    chk("taken_once", {16'd0, taken_cnt}, 32'd1);
`endif
    run(1);
    chk("first_run_pc", pc, 32'h104);

    // Taken with stall in the same cycle still redirects.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h200);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_br_pc", pc, 32'h200);
    run(1);
    chk("stall_br_next", pc, 32'h204);

    // Not-taken branch behaves as a normal cycle.
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("nottaken_pc", pc, 32'h208);
    chk("nottaken_flush", {31'd0, flush}, 32'd0);

    // Back-to-back taken branch on the first RUN cycle after FLUSH.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h400);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h500);
    chk("b2b_pc", pc, 32'h500);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset during FLUSH.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h800);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("midrst_pc", pc, RESET_PC);
    chk("midrst_flush", {31'd0, flush}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);

    // PC wrap from 0xFFFF_FFFC to 0.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run(1);
    chk("wrap_fffc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    run(1);
    chk("wrap_zero", pc, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, $urandom);
    end

`ifdef BRANCH_STATS_EN
    // Counting and saturation.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h40);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("stats_taken3", {16'd0, taken_cnt}, 32'd3);
    chk("stats_nt2", {16'd0, nottaken_cnt}, 32'd2);
    dut.u_stats.taken_q    = 16'hFFFE;
    dut.u_stats.nottaken_q = 16'hFFFE;
    m_tk = 16'hFFFE;
    m_nt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h80);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    chk("sat_taken", {16'd0, taken_cnt}, 32'h0000_FFFF);
    chk("sat_nt", {16'd0, nottaken_cnt}, 32'h0000_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
